// File: rtl/env_pkg.sv
// Shared types and constants for the covert-channel demonstrator.
// Build option: define ENV_LFSR_EN for LFSR victim selection; otherwise round-robin.
package env_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    PRIME,
    SEND,
    PROBE,
    DECIDE,
    DONE
  } state_t;

  localparam int LED_BUSY     = 4;
  localparam int LED_DONE     = 5;
  localparam int LED_MATCH    = 6;
  localparam int LED_MISMATCH = 7;

  // Fibonacci taps 8,6,5,4 on an 8-bit register shifted towards the MSB.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Receiver tags occupy 0..WAYS-1 and sender tags WAYS..2*WAYS-1.
  function automatic int tag_width(input int ways);
    return $clog2(2 * ways);
  endfunction

endpackage

// File: rtl/rand_cache.sv
// WAYS-entry fully-associative tag store with random (ENV_LFSR_EN) or round-robin replacement.
// Hit is combinational for the current access; fills happen on the clock edge.
module rand_cache
  import env_pkg::*;
#(
  parameter int         WAYS      = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         TW        = tag_width(WAYS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          access,
  input  logic [TW-1:0] tag,
  input  logic          flush,
`ifdef ENV_LFSR_EN
  input  logic          step,
`endif
  output logic          hit
);

  localparam int IW = $clog2(WAYS);

  logic [WAYS-1:0] valid;
  logic [TW-1:0]   tags [WAYS];
  logic            free_found;
  logic [IW-1:0]   free_idx;
  logic [IW-1:0]   victim;
  logic [IW-1:0]   fill_idx;
  logic            fill;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid[i] && tags[i] == tag) hit = 1'b1;
    end
  end

  // Downward scan so the last assignment wins: lowest-index invalid way.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign fill     = access && !hit && !flush;
  assign fill_idx = free_found ? free_idx : victim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < WAYS; i++) tags[i] <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (fill) begin
      valid[fill_idx] <= 1'b1;
      tags[fill_idx]  <= tag;
    end
  end

`ifdef ENV_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign victim = lfsr[IW-1:0];
`else
  logic [IW-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (fill && !free_found) begin
      rr_ptr <= rr_ptr + 1'b1;
    end
  end

  assign victim = rr_ptr;
`endif

endmodule

// File: rtl/covert_environment.sv
// FPGA top: sender/receiver covert channel over a shared cache, one secret bit per round.
// Build option: ENV_LFSR_EN selects LFSR replacement inside rand_cache.
module covert_environment
  import env_pkg::*;
#(
  parameter int         WAYS      = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       PB1,
  input  logic [3:0] Y,
  output logic [7:0] led
);

  localparam int TW = tag_width(WAYS);
  localparam int IW = $clog2(WAYS);

  state_t        state;
  logic [3:0]    secret;
  logic [3:0]    rx;
  logic [3:0]    rx_next;
  logic [1:0]    idx;
  logic [IW-1:0] cnt;
  logic [4:0]    misses;
  logic          last;
  logic          access;
  logic [TW-1:0] tag;
  logic          hit;

  assign last    = (cnt == IW'(WAYS - 1));
  assign rx_next = {rx[2:0], (misses != 5'd0)};
  // Sender tags are the receiver tags with the top bit set.
  assign tag     = {(state == SEND), cnt};
  assign access  = (state == PRIME) || (state == PROBE) ||
                   ((state == SEND) && secret[idx]);

  rand_cache #(
    .WAYS      (WAYS),
    .LFSR_SEED (LFSR_SEED),
    .TW        (TW)
  ) u_cache (
    .clk    (clk),
    .rst_n  (PB1),
    .access (access),
    .tag    (tag),
    .flush  (state == FLUSH),
`ifdef ENV_LFSR_EN
    .step   ((state != IDLE) && (state != DONE)),
`endif
    .hit    (hit)
  );

  always_ff @(posedge clk or negedge PB1) begin
    if (!PB1) begin
      state  <= IDLE;
      secret <= '0;
      rx     <= '0;
      idx    <= '0;
      cnt    <= '0;
      misses <= '0;
      led    <= '0;
    end else begin
      case (state)
        IDLE: begin
          secret        <= Y;
          rx            <= '0;
          idx           <= 2'd3;
          cnt           <= '0;
          misses        <= '0;
          led           <= '0;
          led[LED_BUSY] <= 1'b1;
          state         <= FLUSH;
        end
        FLUSH: begin
          cnt   <= '0;
          state <= PRIME;
        end
        PRIME: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) state <= SEND;
        end
        SEND: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) state <= PROBE;
        end
        PROBE: begin
          if (access && !hit && misses != 5'd31) misses <= misses + 5'd1;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) state <= DECIDE;
        end
        DECIDE: begin
          rx       <= rx_next;
          misses   <= '0;
          led[3:0] <= rx_next;
          if (idx == 2'd0) begin
            led[LED_BUSY]     <= 1'b0;
            led[LED_DONE]     <= 1'b1;
            led[LED_MATCH]    <= (rx_next == secret);
            led[LED_MISMATCH] <= (rx_next != secret);
            state             <= DONE;
          end else begin
            idx   <= idx - 2'd1;
            state <= FLUSH;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_covert_environment.sv
// Bench for covert_environment: per-edge LED expectations derived from the round timing
// and the MSB-first decode rule, checked through a scoreboard queue.
module tb_covert_environment;

  localparam int WAYS    = 8;
  localparam int PER_BIT = 3 * WAYS + 2;
  localparam int DONE_AT = 1 + 4 * PER_BIT;

  logic       clk;
  logic       pb1;
  logic [3:0] y;
  logic [7:0] led;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  covert_environment #(.WAYS(WAYS), .LFSR_SEED(8'hA5)) dut (
    .clk (clk),
    .PB1 (pb1),
    .Y   (y),
    .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: led=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected LED after edge e (e >= 1) of a run started with secret s.
  function automatic logic [7:0] model_led(input logic [3:0] s, input int e);
    int k;
    logic [7:0] v;
    if (e >= DONE_AT) begin
      v = {4'b0110, s};
    end else begin
      k = (e - 1) / PER_BIT;
      v = 8'h10 | ({4'b0, s} >> (4 - k));
    end
    return v;
  endfunction

  task automatic do_reset(input int cycles, input logic [3:0] val);
    @(negedge clk);
    pb1 = 1'b0;
    y   = val;
    #1 check_eq("rst_async", led, 8'h00);
    repeat (cycles) @(negedge clk);
    check_eq("rst_hold", led, 8'h00);
    pb1 = 1'b1;
  endtask

  task automatic watch(input logic [3:0] s, input int n_edges, input int toggle_at,
                       input logic [3:0] toggle_val);
    exp_q.delete();
    for (int e = 1; e <= n_edges; e++) exp_q.push_back(model_led(s, e));
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk);
      #1 check_eq($sformatf("y%b_e%0d", s, e), led, exp_q.pop_front());
      if (e == toggle_at) y = toggle_val;
    end
  endtask

  initial begin
    logic [3:0] s;
    logic [3:0] s2;
    int         cut;
    pb1 = 1'b0;
    y   = 4'b0000;

    // Long power-on reset, then the reference secret with a few extra DONE edges.
    do_reset(10000, 4'b1010);
    watch(4'b1010, DONE_AT + 10, 0, 4'b0000);

    do_reset(3, 4'b0000);
    watch(4'b0000, DONE_AT + 3, 0, 4'b0000);

    do_reset(3, 4'b1111);
    watch(4'b1111, DONE_AT + 3, 0, 4'b0000);

    // Input changes after IDLE must not disturb the run.
    do_reset(2, 4'b1010);
    watch(4'b1010, DONE_AT + 3, 30, 4'b0101);

    // Mid-run abort at cycle 60, release at 70, fresh run with a new secret.
    do_reset(2, 4'b0110);
    watch(4'b0110, 60, 0, 4'b0000);
    pb1 = 1'b0;
    y   = 4'b1001;
    #1 check_eq("abort_async", led, 8'h00);
    for (int c = 61; c <= 70; c++) begin
      @(posedge clk);
      #1 check_eq($sformatf("abort_c%0d", c), led, 8'h00);
    end
    @(negedge clk);
    pb1 = 1'b1;
    watch(4'b1001, DONE_AT + 2, 0, 4'b0000);

    // Randomized secrets, reset lengths, late input changes and aborts.
    for (int r = 0; r < 16; r++) begin
      s  = 4'($urandom_range(0, 15));
      s2 = 4'($urandom_range(0, 15));
      do_reset($urandom_range(1, 5), s);
      if (r % 4 == 3) begin
        cut = $urandom_range(2, DONE_AT - 2);
        watch(s, cut, 0, 4'b0000);
        pb1 = 1'b0;
        y   = s2;
        #1 check_eq("rand_abort", led, 8'h00);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        pb1 = 1'b1;
        watch(s2, DONE_AT + 1, 0, 4'b0000);
      end else begin
        watch(s, DONE_AT + 1, $urandom_range(1, DONE_AT), s2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
